// File: rtl/memory_arbiter_if.sv
// Request/completion bundle between pipeline requesters, the arbiter and the shared RAM port.
// Latency: none, wires only.
// Backpressure: requesters hold xREN/dWEN until ihit/dhit; the RAM stalls via ramstate.
interface memory_arbiter_if;
   logic        iREN;
   logic [31:0] iaddr;
   logic        dREN;
   logic        dWEN;
   logic [31:0] daddr;
   logic [31:0] dstore;
   logic        ihit;
   logic [31:0] iload;
   logic        dhit;
   logic [31:0] dload;
   logic        err;
   logic        ramREN;
   logic        ramWEN;
   logic [31:0] ramaddr;
   logic [31:0] ramstore;
   logic [31:0] ramload;
   logic [1:0]  ramstate;

   // Arbiter view: takes requests and RAM status, drives completions and the RAM port.
   modport slave (
      input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
      output ihit, iload, dhit, dload, err, ramREN, ramWEN, ramaddr, ramstore
   );

   // Environment view: pipeline requesters plus the RAM model.
   modport master (
      output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
      input  ihit, iload, dhit, dload, err, ramREN, ramWEN, ramaddr, ramstore
   );
endinterface

// File: rtl/memory_arbiter.sv
// Single-port RAM arbiter: data accesses beat fetches; timeout/error monitor with sticky err.
// Latency: one IDLE arbitration cycle, then hit in the first cycle the RAM reports ACCESS.
// Backpressure: requester holds its request until the hit; dropping it withdraws the access.
module memory_arbiter #(
   parameter int TIMEOUT = 255
) (
   input  logic             CLK,
   input  logic             nRST,
   memory_arbiter_if.slave  bus
);
   localparam int CNT_W = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TIMEOUT - 1);
   localparam logic [1:0]       RS_ACCESS = 2'd2;
   localparam logic [1:0]       RS_ERROR  = 2'd3;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DACC = 2'd1,
      IACC = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             err_q, err_d;

   logic dreq;
   logic in_acc;
   logic owner_live;
   logic ram_access;
   logic abort;
   logic hit;

   // Shared decode: who owns the RAM, whether it is still wanted, and how this cycle ends
   always_comb begin
      dreq       = bus.dREN | bus.dWEN;
      in_acc     = (state_q == DACC) || (state_q == IACC);
      owner_live = (state_q == DACC) ? dreq : bus.iREN;
      ram_access = (bus.ramstate == RS_ACCESS);
      abort      = in_acc && ((bus.ramstate == RS_ERROR) ||
                              ((cnt_q == CNT_LAST) && !ram_access));
      hit        = in_acc && owner_live && ram_access;
   end

   // State register
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // Next state: data wins arbitration; any completion, withdrawal or abort returns to IDLE
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (dreq)          state_d = DACC;
            else if (bus.iREN) state_d = IACC;
         end
         DACC, IACC: begin
            if (!owner_live || ram_access || abort) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Stall counter restarts from zero on every entry; err latches any abort
   always_comb begin
      cnt_d = '0;
      if (in_acc) cnt_d = ram_access ? cnt_q : cnt_q + 1'b1;
      err_d = err_q | abort;
   end

   // Stall counter and sticky error registers
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         cnt_q <= '0;
         err_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         err_q <= err_d;
      end
   end

   // Outputs: RAM port follows the owner; enables naturally drop when the owner withdraws
   always_comb begin
      bus.ramREN   = 1'b0;
      bus.ramWEN   = 1'b0;
      bus.ramaddr  = '0;
      bus.ramstore = '0;
      bus.ihit     = 1'b0;
      bus.dhit     = 1'b0;
      bus.iload    = '0;
      bus.dload    = '0;
      bus.err      = err_q;
      case (state_q)
         DACC: begin
            bus.ramaddr  = bus.daddr;
            bus.ramstore = bus.dstore;
            bus.ramWEN   = bus.dWEN;
            bus.ramREN   = bus.dREN & ~bus.dWEN;
            bus.dhit     = hit;
            bus.dload    = hit ? bus.ramload : '0;
         end
         IACC: begin
            bus.ramaddr  = bus.iaddr;
            bus.ramREN   = bus.iREN;
            bus.ihit     = hit;
            bus.iload    = hit ? bus.ramload : '0;
         end
         default: ;
      endcase
   end
endmodule

// File: tb/tb_memory_arbiter.sv
// Bench for memory_arbiter: directed scenarios plus randomized traffic against a reference model.
// Latency: inputs change 1 time unit after the rising edge, outputs sampled on the falling edge.
// Backpressure: the RAM side is modelled by driving ramstate FREE/BUSY/ACCESS/ERROR.
module tb_memory_arbiter;
   localparam int TMO = 4;
   localparam logic [1:0] FREE = 2'd0, BUSY = 2'd1, ACC = 2'd2, ERR = 2'd3;

   logic CLK = 1'b0;
   logic nRST;
   always #5 CLK = ~CLK;

   memory_arbiter_if bus();
   memory_arbiter #(.TIMEOUT(TMO)) dut (.CLK(CLK), .nRST(nRST), .bus(bus));

   int n_chk = 0;
   int n_err = 0;

   // Reference model: who owns the RAM (0 none, 1 data, 2 fetch), stalled cycles so far, error flag
   int m_own   = 0;
   int m_stall = 0;
   bit m_err   = 1'b0;

   // Last sampled outputs, for scenario-specific checks after a cycle
   logic [31:0] ob_addr, ob_store, ob_iload, ob_dload;
   logic        ob_ren, ob_wen, ob_ihit, ob_dhit, ob_err;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   task automatic drive(input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
                        input logic [31:0] da, input logic [31:0] ds,
                        input logic [1:0] rs, input logic [31:0] rl);
      bus.iREN = ir;  bus.iaddr = ia;
      bus.dREN = dr;  bus.dWEN = dw;  bus.daddr = da;  bus.dstore = ds;
      bus.ramstate = rs;  bus.ramload = rl;
   endtask

   // One clock: compare every output against the model, then advance the model across the edge
   task automatic cycle();
      logic [31:0] e_addr, e_store, e_iload, e_dload;
      logic [31:0] e_ren, e_wen, e_ihit, e_dhit;
      bit dreq, stalled, abort, done;
      @(negedge CLK);
      ob_addr = bus.ramaddr;  ob_store = bus.ramstore;  ob_ren = bus.ramREN;  ob_wen = bus.ramWEN;
      ob_ihit = bus.ihit;     ob_dhit  = bus.dhit;      ob_iload = bus.iload; ob_dload = bus.dload;
      ob_err  = bus.err;
      e_addr = 32'h0; e_store = 32'h0; e_iload = 32'h0; e_dload = 32'h0;
      e_ren = 32'h0;  e_wen = 32'h0;   e_ihit = 32'h0;  e_dhit = 32'h0;
      dreq    = bus.dREN || bus.dWEN;
      stalled = (bus.ramstate != ACC);
      abort   = 1'b0;
      done    = 1'b0;
      if (m_own != 0) begin
         abort = (bus.ramstate == ERR) || (stalled && (m_stall + 1 == TMO));
         done  = !stalled || abort || (m_own == 1 ? !dreq : !bus.iREN);
      end
      if (m_own == 1) begin
         e_addr  = bus.daddr;
         e_store = bus.dstore;
         e_wen   = 32'(bus.dWEN);
         e_ren   = 32'(bus.dREN && !bus.dWEN);
         if (dreq && !stalled) begin
            e_dhit  = 32'h1;
            e_dload = bus.ramload;
         end
      end else if (m_own == 2) begin
         e_addr = bus.iaddr;
         e_ren  = 32'(bus.iREN);
         if (bus.iREN && !stalled) begin
            e_ihit  = 32'h1;
            e_iload = bus.ramload;
         end
      end
      chk("ramaddr", ob_addr, e_addr);
      if (m_own != 2) chk("ramstore", ob_store, e_store);
      chk("ramREN", 32'(ob_ren), e_ren);
      chk("ramWEN", 32'(ob_wen), e_wen);
      chk("ihit", 32'(ob_ihit), e_ihit);
      chk("iload", ob_iload, e_iload);
      chk("dhit", 32'(ob_dhit), e_dhit);
      chk("dload", ob_dload, e_dload);
      chk("err", 32'(ob_err), 32'(m_err));
      if (abort) m_err = 1'b1;
      if (m_own == 0) begin
         m_stall = 0;
         if (dreq) m_own = 1;
         else if (bus.iREN) m_own = 2;
      end else if (done) begin
         m_own = 0;
      end else begin
         m_stall++;
      end
      @(posedge CLK);
      #1;
   endtask

   // Asynchronous reset pulse; outputs must clear before any clock edge
   task automatic do_reset();
      nRST = 1'b0;
      #1;
      chk("rst_ramREN", 32'(bus.ramREN), 32'h0);
      chk("rst_ramWEN", 32'(bus.ramWEN), 32'h0);
      chk("rst_ramaddr", bus.ramaddr, 32'h0);
      chk("rst_ramstore", bus.ramstore, 32'h0);
      chk("rst_hits", 32'({bus.ihit, bus.dhit}), 32'h0);
      chk("rst_loads", bus.iload | bus.dload, 32'h0);
      chk("rst_err", 32'(bus.err), 32'h0);
      m_own = 0; m_stall = 0; m_err = 1'b0;
      @(posedge CLK);
      #1;
      nRST = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected bench completion");
      $fatal(1, "bench did not complete");
   end

   initial begin
      bit ir, dr, dw;
      logic [31:0] ia, da, ds;
      int r;
      logic [1:0] rs;

      nRST = 1'b0;
      drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, FREE, 32'h0);
      @(posedge CLK);
      #1;
      do_reset();

      // Fetch with two BUSY cycles: hit at request+3
      drive(1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0, FREE, 32'h0);         cycle();
      drive(1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0, BUSY, 32'h0);         cycle();
      chk("fetch_c1_ren", 32'(ob_ren), 32'h1);
      chk("fetch_c1_addr", ob_addr, 32'h40);
      cycle();
      chk("fetch_c2_ihit", 32'(ob_ihit), 32'h0);
      drive(1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0, ACC, 32'h8C220004);   cycle();
      chk("fetch_c3_ihit", 32'(ob_ihit), 32'h1);
      chk("fetch_c3_iload", ob_iload, 32'h8C220004);
      drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, FREE, 32'h0);          cycle();
      chk("fetch_c4_ihit", 32'(ob_ihit), 32'h0);

      // Data beats fetch, fetch follows after one IDLE cycle
      drive(1'b1, 32'h40, 1'b1, 1'b0, 32'h100, 32'h0, FREE, 32'h0);       cycle();
      drive(1'b1, 32'h40, 1'b1, 1'b0, 32'h100, 32'h0, ACC, 32'h11111111); cycle();
      chk("prio_c1_addr", ob_addr, 32'h100);
      chk("prio_c1_dhit", 32'(ob_dhit), 32'h1);
      chk("prio_c1_ihit", 32'(ob_ihit), 32'h0);
      drive(1'b1, 32'h40, 1'b0, 1'b0, 32'h100, 32'h0, FREE, 32'h0);       cycle();
      chk("prio_c2_idle", 32'({ob_ren, ob_wen}) | ob_addr, 32'h0);
      drive(1'b1, 32'h40, 1'b0, 1'b0, 32'h100, 32'h0, ACC, 32'h22222222); cycle();
      chk("prio_c3_addr", ob_addr, 32'h40);
      chk("prio_c3_ren", 32'(ob_ren), 32'h1);
      chk("prio_c3_ihit", 32'(ob_ihit), 32'h1);
      drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, FREE, 32'h0);          cycle();

      // Read+write together: the write wins
      drive(1'b0, 32'h0, 1'b1, 1'b1, 32'h200, 32'hDEADBEEF, FREE, 32'h0); cycle();
      drive(1'b0, 32'h0, 1'b1, 1'b1, 32'h200, 32'hDEADBEEF, BUSY, 32'h0); cycle();
      chk("wr_wen", 32'(ob_wen), 32'h1);
      chk("wr_ren", 32'(ob_ren), 32'h0);
      chk("wr_store", ob_store, 32'hDEADBEEF);
      drive(1'b0, 32'h0, 1'b1, 1'b1, 32'h200, 32'hDEADBEEF, ACC, 32'h0);  cycle();
      chk("wr_dhit", 32'(ob_dhit), 32'h1);
      chk("wr_dload", ob_dload, 32'h0);
      drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, FREE, 32'h0);          cycle();

      // Fetch withdrawn in the same cycle the RAM completes
      drive(1'b1, 32'h80, 1'b0, 1'b0, 32'h0, 32'h0, FREE, 32'h0);         cycle();
      drive(1'b1, 32'h80, 1'b0, 1'b0, 32'h0, 32'h0, BUSY, 32'h0);         cycle();
      drive(1'b0, 32'h80, 1'b0, 1'b0, 32'h0, 32'h0, ACC, 32'h55AA55AA);   cycle();
      chk("wd_ihit", 32'(ob_ihit), 32'h0);
      chk("wd_ren", 32'(ob_ren), 32'h0);
      drive(1'b1, 32'h84, 1'b0, 1'b0, 32'h0, 32'h0, FREE, 32'h0);         cycle();
      chk("wd_next_idle", 32'(ob_ren), 32'h0);
      drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, FREE, 32'h0);          cycle();

      // Timeout: RAM held BUSY, abort on the 4th access cycle
      drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h300, 32'h0, FREE, 32'h0);        cycle();
      drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h300, 32'h0, BUSY, 32'h0);
      for (int i = 0; i < TMO; i++) cycle();
      chk("tmo_last_dhit", 32'(ob_dhit), 32'h0);
      chk("tmo_last_err", 32'(ob_err), 32'h0);
      cycle();
      chk("tmo_err", 32'(ob_err), 32'h1);
      chk("tmo_idle", 32'(ob_ren), 32'h0);
      drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, FREE, 32'h0);          cycle();
      do_reset();

      // ERROR status: err next edge, stays set through a later good access
      drive(1'b1, 32'h44, 1'b0, 1'b0, 32'h0, 32'h0, FREE, 32'h0);         cycle();
      drive(1'b1, 32'h44, 1'b0, 1'b0, 32'h0, 32'h0, ERR, 32'h0);          cycle();
      chk("erst_ihit", 32'(ob_ihit), 32'h0);
      chk("erst_err_before", 32'(ob_err), 32'h0);
      drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h400, 32'h0, FREE, 32'h0);        cycle();
      chk("erst_err_after", 32'(ob_err), 32'h1);
      drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h400, 32'h0, ACC, 32'hCAFEF00D);  cycle();
      chk("erst_dhit", 32'(ob_dhit), 32'h1);
      chk("erst_err_sticky", 32'(ob_err), 32'h1);

      // Reset in the middle of a data read with ramREN high
      drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h500, 32'h0, FREE, 32'h0);        cycle();
      drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h500, 32'h0, BUSY, 32'h0);
      #1;
      chk("midrst_ren_before", 32'(bus.ramREN), 32'h1);
      do_reset();
      drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, FREE, 32'h0);

      // Randomized traffic with occasional resets
      ir = 1'b0; dr = 1'b0; dw = 1'b0; ia = 32'h0; da = 32'h0; ds = 32'h0;
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 3) == 0) ir = ($urandom_range(0, 9) < 6);
         if ($urandom_range(0, 3) == 0) begin
            dr = ($urandom_range(0, 9) < 3);
            dw = ($urandom_range(0, 9) < 2);
         end
         if ($urandom_range(0, 3) == 0) begin
            ia = $urandom; da = $urandom; ds = $urandom;
         end
         r  = $urandom_range(0, 99);
         rs = (r < 10) ? FREE : (r < 55) ? BUSY : (r < 97) ? ACC : ERR;
         drive(ir, ia, dr, dw, da, ds, rs, $urandom);
         if ($urandom_range(0, 299) == 0) do_reset();
         else cycle();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
